// File: rtl/tl_io_slave_responder.sv
// Uncached single-beat TileLink manager endpoint: services builtin Get/Put acquires
// against a local beat-wide scratch/MMIO array and returns one grant per acquire.
module tl_io_slave_responder #(
  parameter int          IDX_W      = 6,
  parameter logic [25:0] BASE_BLOCK = 26'h0,
  parameter logic [3:0]  MANAGER_ID = 4'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_acquire_valid,
  output logic         io_acquire_ready,
  input  logic [25:0]  io_acquire_bits_addr_block,
  input  logic [1:0]   io_acquire_bits_client_xact_id,
  input  logic [1:0]   io_acquire_bits_addr_beat,
  input  logic         io_acquire_bits_is_builtin_type,
  input  logic [2:0]   io_acquire_bits_a_type,
  input  logic [16:0]  io_acquire_bits_union,
  input  logic [127:0] io_acquire_bits_data,
  input  logic         io_grant_ready,
  output logic         io_grant_valid,
  output logic [1:0]   io_grant_bits_addr_beat,
  output logic [1:0]   io_grant_bits_client_xact_id,
  output logic [3:0]   io_grant_bits_manager_xact_id,
  output logic         io_grant_bits_is_builtin_type,
  output logic [3:0]   io_grant_bits_g_type,
  output logic [127:0] io_grant_bits_data,
  output logic         io_err
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_nextState;

  logic [25:0]  r_addrBlock;
  logic [1:0]   r_addrBeat;
  logic [1:0]   r_xactId;
  logic         r_builtin;
  logic [2:0]   r_aType;
  logic [15:0]  r_mask;
  logic [127:0] r_data;
  logic [127:0] r_grantData;
  logic         r_err;
  logic [127:0] r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  logic             w_isGet;
  logic             w_isPut;
  logic             w_unused;

  // The low block bits concatenated with the beat select the array word;
  // the remaining high block bits must match the region base to hit.
  assign w_idx    = IDX_W'({r_addrBlock, r_addrBeat});
  assign w_hit    = (r_addrBlock >> (IDX_W - 2)) == (BASE_BLOCK >> (IDX_W - 2));
  assign w_isGet  = r_builtin && (r_aType == 3'd0);
  assign w_isPut  = r_builtin && (r_aType == 3'd2);
  assign w_unused = io_acquire_bits_union[0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState      = r_state;
    io_acquire_ready = 1'b0;
    io_grant_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        io_acquire_ready = 1'b1;
        if (io_acquire_valid) w_nextState = ACCESS;
      end
      ACCESS: w_nextState = GRANT;
      GRANT: begin
        io_grant_valid = 1'b1;
        if (io_grant_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addrBlock <= '0;
      r_addrBeat  <= '0;
      r_xactId    <= '0;
      r_builtin   <= 1'b0;
      r_aType     <= '0;
      r_mask      <= '0;
      r_data      <= '0;
    end else if (r_state == IDLE && io_acquire_valid) begin
      r_addrBlock <= io_acquire_bits_addr_block;
      r_addrBeat  <= io_acquire_bits_addr_beat;
      r_xactId    <= io_acquire_bits_client_xact_id;
      r_builtin   <= io_acquire_bits_is_builtin_type;
      r_aType     <= io_acquire_bits_a_type;
      r_mask      <= io_acquire_bits_union[16:1];
      r_data      <= io_acquire_bits_data;
    end
  end

  // The array access happens in the single ACCESS cycle, so a Put is complete
  // before its ack is visible and a reset there aborts the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grantData <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ACCESS) begin
      r_grantData <= '0;
      if (w_isGet && w_hit) begin
        r_grantData <= r_mem[w_idx];
      end else if (w_isPut && w_hit) begin
        for (int b = 0; b < 16; b++) begin
          if (r_mask[b]) r_mem[w_idx][8*b +: 8] <= r_data[8*b +: 8];
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_grant_bits_addr_beat       = r_addrBeat;
  assign io_grant_bits_client_xact_id  = r_xactId;
  assign io_grant_bits_manager_xact_id = MANAGER_ID;
  assign io_grant_bits_is_builtin_type = 1'b1;
  assign io_grant_bits_g_type          = w_isGet ? 4'h4 : 4'h3;
  assign io_grant_bits_data            = r_grantData;
  assign io_err                        = r_err;

endmodule

// File: tb/tb_tl_io_slave_responder.sv
// Randomized scoreboard bench for tl_io_slave_responder against a flat-array
// reference model of the scratch region.
module tb_tl_io_slave_responder;

  localparam int          IDX_W   = 6;
  localparam logic [25:0] BASE    = 26'h40;
  localparam logic [3:0]  MGR_ID  = 4'h5;
  localparam int          NBLOCKS = 2 ** (IDX_W - 2);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_acquire_valid = 1'b0;
  logic         io_acquire_ready;
  logic [25:0]  io_acquire_bits_addr_block = '0;
  logic [1:0]   io_acquire_bits_client_xact_id = '0;
  logic [1:0]   io_acquire_bits_addr_beat = '0;
  logic         io_acquire_bits_is_builtin_type = 1'b0;
  logic [2:0]   io_acquire_bits_a_type = '0;
  logic [16:0]  io_acquire_bits_union = '0;
  logic [127:0] io_acquire_bits_data = '0;
  logic         io_grant_ready = 1'b0;
  logic         io_grant_valid;
  logic [1:0]   io_grant_bits_addr_beat;
  logic [1:0]   io_grant_bits_client_xact_id;
  logic [3:0]   io_grant_bits_manager_xact_id;
  logic         io_grant_bits_is_builtin_type;
  logic [3:0]   io_grant_bits_g_type;
  logic [127:0] io_grant_bits_data;
  logic         io_err;

  tl_io_slave_responder #(.IDX_W(IDX_W), .BASE_BLOCK(BASE), .MANAGER_ID(MGR_ID)) dut (
    .clk(clk), .reset(reset),
    .io_acquire_valid(io_acquire_valid), .io_acquire_ready(io_acquire_ready),
    .io_acquire_bits_addr_block(io_acquire_bits_addr_block),
    .io_acquire_bits_client_xact_id(io_acquire_bits_client_xact_id),
    .io_acquire_bits_addr_beat(io_acquire_bits_addr_beat),
    .io_acquire_bits_is_builtin_type(io_acquire_bits_is_builtin_type),
    .io_acquire_bits_a_type(io_acquire_bits_a_type),
    .io_acquire_bits_union(io_acquire_bits_union),
    .io_acquire_bits_data(io_acquire_bits_data),
    .io_grant_ready(io_grant_ready), .io_grant_valid(io_grant_valid),
    .io_grant_bits_addr_beat(io_grant_bits_addr_beat),
    .io_grant_bits_client_xact_id(io_grant_bits_client_xact_id),
    .io_grant_bits_manager_xact_id(io_grant_bits_manager_xact_id),
    .io_grant_bits_is_builtin_type(io_grant_bits_is_builtin_type),
    .io_grant_bits_g_type(io_grant_bits_g_type),
    .io_grant_bits_data(io_grant_bits_data),
    .io_err(io_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   beat;
    logic [1:0]   xid;
    logic [3:0]   gType;
    logic [127:0] data;
    logic         err;
  } grant_t;

  grant_t       expQ[$];
  logic [127:0] modelMem [NBLOCKS*4];
  logic         modelErr;
  int           nChecks = 0;
  int           nFail = 0;
  bit           stallMode = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NBLOCKS*4; i++) modelMem[i] = '0;
    modelErr = 1'b0;
  endtask

  // Reference behaviour: the region is NBLOCKS blocks starting at BASE, four beats each.
  function automatic grant_t modelAcquire(input logic [25:0] block, input logic [1:0] beat,
      input logic [1:0] xid, input logic builtin, input logic [2:0] atype,
      input logic [15:0] mask, input logic [127:0] data);
    grant_t e;
    bit inRange = (block >= BASE) && (block < BASE + NBLOCKS);
    bit isGet = builtin && atype == 3'd0;
    bit isPut = builtin && atype == 3'd2;
    int off = (int'(block) - int'(BASE)) * 4 + int'(beat);
    e.beat = beat;
    e.xid = xid;
    e.gType = isGet ? 4'h4 : 4'h3;
    e.data = '0;
    if (!(isGet || isPut) || !inRange) modelErr = 1'b1;
    else if (isGet) e.data = modelMem[off];
    else
      for (int b = 0; b < 16; b++)
        if (mask[b]) modelMem[off][8*b +: 8] = data[8*b +: 8];
    e.err = modelErr;
    return e;
  endfunction

  task automatic waitIdle();
    int waitCnt = 0;
    @(negedge clk);
    while (!io_acquire_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!io_acquire_ready) checkOutput("acquire_ready_timeout", 128'(io_acquire_ready), 128'd1);
  endtask

  task automatic driveAcquire(input logic [25:0] block, input logic [1:0] beat, input logic [1:0] xid,
      input logic builtin, input logic [2:0] atype, input logic [15:0] mask, input logic [127:0] data);
    io_acquire_bits_addr_block      = block;
    io_acquire_bits_addr_beat       = beat;
    io_acquire_bits_client_xact_id  = xid;
    io_acquire_bits_is_builtin_type = builtin;
    io_acquire_bits_a_type          = atype;
    io_acquire_bits_union           = {mask, 1'($urandom_range(0, 1))};
    io_acquire_bits_data            = data;
    io_acquire_valid                = 1'b1;
    @(posedge clk);
    #1 io_acquire_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [25:0] block, input logic [1:0] beat, input logic [1:0] xid,
      input logic builtin, input logic [2:0] atype, input logic [15:0] mask, input logic [127:0] data);
    waitIdle();
    expQ.push_back(modelAcquire(block, beat, xid, builtin, atype, mask, data));
    driveAcquire(block, beat, xid, builtin, atype, mask, data);
    @(negedge clk);
    checkOutput("grant_valid_access_cycle", 128'(io_grant_valid), 128'd0);
    @(negedge clk);
    checkOutput("grant_valid_latency", 128'(io_grant_valid), 128'd1);
    checkOutput("acquire_ready_in_grant", 128'(io_acquire_ready), 128'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 io_grant_ready = stallMode ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    grant_t e;
    forever begin
      @(negedge clk);
      if (!reset && io_grant_valid && io_grant_ready) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpected_grant: got a grant, expected none");
        end else begin
          e = expQ.pop_front();
          checkOutput("grant_beat", 128'(io_grant_bits_addr_beat), 128'(e.beat));
          checkOutput("grant_xid", 128'(io_grant_bits_client_xact_id), 128'(e.xid));
          checkOutput("grant_mgr_id", 128'(io_grant_bits_manager_xact_id), 128'(MGR_ID));
          checkOutput("grant_builtin", 128'(io_grant_bits_is_builtin_type), 128'd1);
          checkOutput("grant_g_type", 128'(io_grant_bits_g_type), 128'(e.gType));
          checkOutput("grant_data", io_grant_bits_data, e.data);
          checkOutput("err_flag", 128'(io_err), 128'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waitCnt;
    logic [25:0]  blk;
    logic [127:0] rdata;
    modelReset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_acquire_ready", 128'(io_acquire_ready), 128'd1);
    checkOutput("reset_grant_valid", 128'(io_grant_valid), 128'd0);
    checkOutput("reset_grant_data", io_grant_bits_data, 128'd0);
    checkOutput("reset_err", 128'(io_err), 128'd0);

    applyStimulus(BASE, 2'd1, 2'd2, 1'b1, 3'd2, 16'hFFFF, 128'h00112233445566778899AABBCCDDEEFF);
    applyStimulus(BASE, 2'd1, 2'd3, 1'b1, 3'd0, 16'h0000, 128'd0);
    applyStimulus(BASE + 26'd3, 2'd2, 2'd1, 1'b1, 3'd2, 16'h00F0, {128{1'b1}});
    applyStimulus(BASE + 26'd3, 2'd2, 2'd0, 1'b1, 3'd0, 16'h0000, 128'd0);

    stallMode = 1'b1;
    applyStimulus(BASE, 2'd1, 2'd1, 1'b1, 3'd0, 16'h0000, 128'd0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_grant_valid", 128'(io_grant_valid), 128'd1);
      checkOutput("stall_acquire_ready", 128'(io_acquire_ready), 128'd0);
      checkOutput("stall_grant_data", io_grant_bits_data, expQ[0].data);
      checkOutput("stall_g_type", 128'(io_grant_bits_g_type), 128'(expQ[0].gType));
      checkOutput("stall_xid", 128'(io_grant_bits_client_xact_id), 128'(expQ[0].xid));
    end
    stallMode = 1'b0;

    // Abort a Put with reset while it is in the access cycle.
    waitIdle();
    driveAcquire(BASE + 26'd5, 2'd0, 2'd2, 1'b1, 3'd2, 16'hFFFF, {4{32'hDEADBEEF}});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort_no_grant", 128'(io_grant_valid), 128'd0);
    end
    applyStimulus(BASE + 26'd5, 2'd0, 2'd3, 1'b1, 3'd0, 16'h0000, 128'd0);

    applyStimulus(BASE + 26'(NBLOCKS), 2'd1, 2'd0, 1'b1, 3'd0, 16'h0000, 128'd0);
    applyStimulus(BASE + 26'd2, 2'd3, 2'd1, 1'b1, 3'd3, 16'hFFFF, {4{32'hA5A5A5A5}});
    applyStimulus(BASE + 26'd2, 2'd3, 2'd2, 1'b0, 3'd2, 16'hFFFF, {4{32'h5A5A5A5A}});
    applyStimulus(BASE + 26'd2, 2'd3, 2'd3, 1'b1, 3'd0, 16'h0000, 128'd0);
    applyStimulus(BASE, 2'd1, 2'd0, 1'b1, 3'd0, 16'h0000, 128'd0);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 11))
        0:       blk = BASE + 26'(NBLOCKS) + 26'($urandom_range(0, 40));
        1:       blk = BASE - 26'd1 - 26'($urandom_range(0, 3));
        default: blk = BASE + 26'($urandom_range(0, NBLOCKS - 1));
      endcase
      rdata = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(blk, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 15) != 0),
                    ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : ($urandom_range(0, 1) ? 3'd2 : 3'd0),
                    16'($urandom_range(0, 65535)), rdata);
    end

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("pending_grants_drained", 128'(expQ.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
